// File: rtl/codec_cfg_sequencer.sv
// Codec register configuration sequencer driving a shared I2C write engine.
// Power-up wait, 11-entry init table with NACK retry, then runtime writes.
module codec_cfg_sequencer #(
  parameter int         POWERUP_CYCLES = 1000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] DEV_ADDR       = 8'h34
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_dev,
  output logic [15:0] wr_word,
  input  logic        wr_done,
  input  logic        wr_nack,
  input  logic        usr_valid,
  output logic        usr_ready,
  input  logic [6:0]  usr_addr,
  input  logic [8:0]  usr_data,
  output logic        init_done,
  output logic        busy,
  output logic        error,
  output logic [6:0]  err_addr
);

  localparam int CW = $clog2(POWERUP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_READY,
    S_ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [2:0]    retry;

  function automatic logic [15:0] tbl(input logic [3:0] i);
    unique case (i)
      4'd0:    tbl = {7'd15, 9'h000};
      4'd1:    tbl = {7'd0,  9'h097};
      4'd2:    tbl = {7'd1,  9'h097};
      4'd3:    tbl = {7'd2,  9'h079};
      4'd4:    tbl = {7'd3,  9'h079};
      4'd5:    tbl = {7'd4,  9'h015};
      4'd6:    tbl = {7'd5,  9'h000};
      4'd7:    tbl = {7'd6,  9'h000};
      4'd8:    tbl = {7'd7,  9'h002};
      4'd9:    tbl = {7'd8,  9'h00C};
      default: tbl = {7'd9,  9'h001};
    endcase
  endfunction

  assign wr_dev = DEV_ADDR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_PWRUP;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      wr_valid  <= 1'b0;
      wr_word   <= '0;
      usr_ready <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
    end else begin
      unique case (state)
        S_PWRUP: begin
          if (cnt == CW'(POWERUP_CYCLES - 1)) begin
            state    <= S_ISSUE;
            idx      <= '0;
            wr_word  <= tbl(4'd0);
            wr_valid <= 1'b1;
            busy     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (wr_ready) begin
            state    <= S_WAIT;
            wr_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wr_done) begin
            if (!wr_nack) begin
              state <= S_NEXT;
            end else if (retry < 3'(MAX_RETRY)) begin
              retry    <= retry + 1'b1;
              state    <= S_ISSUE;
              wr_valid <= 1'b1;
            end else begin
              err_addr <= wr_word[15:9];
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= S_ERROR;
            end
          end
        end
        S_NEXT: begin
          retry <= '0;
          // user writes come back to READY; init writes walk the table
          if (init_done || idx >= 4'd10) begin
            init_done <= 1'b1;
            usr_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_READY;
          end else begin
            idx      <= idx + 1'b1;
            wr_word  <= tbl(idx + 4'd1);
            wr_valid <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_READY: begin
          if (usr_valid) begin
            wr_word   <= {usr_addr, usr_data};
            usr_ready <= 1'b0;
            wr_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ERROR: begin
          wr_valid  <= 1'b0;
          usr_ready <= 1'b0;
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Sequences the audio codec's register configuration over a shared byte-level I2C write engine. After reset it waits a power-up interval, then writes an 11-entry register table, retrying each write on NACK. Once configuration completes, it serves runtime register-write requests (volume, mute, sample rate) from the datapath control logic. It is the only master of the I2C write engine.

## Interface
- `POWERUP_CYCLES`, default 1000: clocks to wait after reset before the first write (≥1).
- `MAX_RETRY`, default 3: retries per write after the first attempt (0..7).
- `DEV_ADDR`, default 8'h34: codec write address byte (R/W bit = 0).

Ports:
- `clk`, in, 1: system clock; all logic runs on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `wr_valid`, out, 1: write request to the I2C engine.
- `wr_ready`, in, 1: engine accepts the request; transfer occurs when `wr_valid && wr_ready`.
- `wr_dev`, out, 8: device address byte; always `DEV_ADDR`.
- `wr_word`, out, 16: `{reg_addr[6:0], reg_data[8:0]}`, sent MSB first as two bytes.
- `wr_done`, in, 1: one-cycle pulse when the engine finishes the transaction.
- `wr_nack`, in, 1: qualified by `wr_done`; 1 means any byte was NACKed.
- `usr_valid`, in, 1: runtime write request.
- `usr_ready`, out, 1: request accepted when `usr_valid && usr_ready`.
- `usr_addr`, in, 7: runtime register address.
- `usr_data`, in, 9: runtime register data.
- `init_done`, out, 1: high once all table writes have succeeded.
- `busy`, out, 1: a transaction is requested or in flight.
- `error`, out, 1: sticky; a write has exhausted its retries.
- `err_addr`, out, 7: register address of the failing write.

## Operation
- Init table, in order, given as (addr, data):
  - R15 = 0x000 (reset)
  - R0 = 0x097, R1 = 0x097
  - R2 = 0x079, R3 = 0x079
  - R4 = 0x015, R5 = 0x000, R6 = 0x000
  - R7 = 0x002, R8 = 0x00C
  - R9 = 0x001 (activate, always last)
- States:
  - PWRUP: counter runs from 0 to `POWERUP_CYCLES-1`, then goes to ISSUE with table index 0.
  - ISSUE: `wr_valid`=1 with `wr_word` taken from the current source. On handshake, go to WAIT.
  - WAIT: `wr_valid`=0. On `wr_done`:
    - `wr_nack`=0: success, go to NEXT.
    - `wr_nack`=1 and retry count < `MAX_RETRY`: increment retry count, go to ISSUE with the same word.
    - `wr_nack`=1 otherwise: load `err_addr`, go to ERROR.
  - NEXT: clear retry count. If index < 10, increment the index and go to ISSUE. Otherwise set `init_done` and go to READY.
  - READY: `usr_ready`=1. On handshake, latch `usr_addr`/`usr_data` into a holding register and go to ISSUE (source = user). After a successful user write, return to READY.
  - ERROR: terminal. `wr_valid`=0 and `usr_ready`=0 until reset.
- `usr_ready`=0 in every state except READY. User requests during init or while busy are held off, never dropped.
- `wr_word` is stable whenever `wr_valid`=1.
- A user write that fails after its retries also enters ERROR. `init_done` stays 1.
- `busy` = state ∈ {ISSUE, WAIT, NEXT}.
- Index is 4 bits, retry count 3 bits, power-up counter sized by `$clog2(POWERUP_CYCLES+1)`.

## Timing
- Reset values: state PWRUP, `wr_valid`=0, `wr_word`=0, `wr_dev`=`DEV_ADDR`, `usr_ready`=0, `init_done`=0, `busy`=0, `error`=0, `err_addr`=0. Counters are 0.
- Reset mid-transaction aborts immediately and restarts from PWRUP. The I2C engine is reset by the same `rst`.
- First `wr_valid` rises `POWERUP_CYCLES` clocks after `rst` deasserts.
- After a success `wr_done`, the next `wr_valid` rises 2 clocks later (WAIT→NEXT→ISSUE).
- After a NACK `wr_done`, the retry `wr_valid` rises 1 clock later.
- `init_done` rises 2 clocks after the 11th successful `wr_done`. `usr_ready` rises in the same cycle.
- After user acceptance, `wr_valid` rises on the next clock.
- `wr_done` outside WAIT is ignored.
- `wr_nack` without `wr_done` is ignored.
- `wr_ready` may stay low indefinitely. The sequencer holds in ISSUE with no timeout.

## Test plan
- Clean init: engine model acks every write, `wr_ready`=1. Expect exactly 11 handshakes in the table order, words 0x1E00, 0x0097, 0x0297, …, 0x1201. `init_done`=1 and `error`=0 afterwards.
- Power-up timing: `POWERUP_CYCLES`=5. First `wr_valid` at clock 5 after reset release. None earlier.
- Retry recovery: NACK on the first two attempts of R4. Expect the same word 0x0815 issued 3 times, then R5 follows. `error`=0.
- Retry exhaustion: NACK all attempts of R7 with `MAX_RETRY`=3. Expect 4 attempts, `error`=1, `err_addr`=7. No further `wr_valid`. `init_done`=0.
- Runtime arbitration: hold `usr_valid`=1 (R2 = 0x07F) from reset. Expect `usr_ready`=0 until `init_done`, then acceptance and word 0x047F issued after R9. Back-to-back user requests are each accepted only after the prior write completes.
- Reset mid-operation: assert `rst` during WAIT of entry 5. Expect all outputs at reset values. On release, the sequence restarts at R15 after the power-up delay.
